// File: rtl/usb_pkg.sv
// Shared state encoding and line constants for the USB full-speed transmit path.
// Line states are packed as {dp, dm}.
package usb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      STUFF,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam int         MAX_ONES     = 6;
   localparam int         EOP_SE0_BITS = 2;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line encoder: on bit_tick the next line bit is registered onto dp/dm one cycle later.
// A 0 toggles J/K, a 1 holds; se0_req drives SE0 and j_req forces the idle J level.
module usb_nrzi_enc
   import usb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic bit_tick,
   input  logic bit_in,
   input  logic se0_req,
   input  logic j_req,
   output logic dp,
   output logic dm
);

   logic       level_q, level_d;
   logic [1:0] line_q, line_d;

   always_comb begin
      level_d = level_q;
      line_d  = line_q;
      if (bit_tick) begin
         if (se0_req) begin
            // SE0 leaves the NRZI level untouched
            line_d = LINE_SE0;
         end else begin
            if (j_req) begin
               level_d = 1'b1;
            end else if (!bit_in) begin
               level_d = ~level_q;
            end
            line_d = level_d ? LINE_J : LINE_K;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 1'b1;
         line_q  <= LINE_J;
      end else begin
         level_q <= level_d;
         line_q  <= line_d;
      end
   end

   assign {dp, dm} = line_q;

endmodule

// File: rtl/usb_tx_serializer.sv
// Serializes one word per packet as SYNC, bit-stuffed LSB-first data and EOP onto dp/dm.
// First SYNC bit appears the cycle after accept; tx_ready is high only while idle.
module usb_tx_serializer
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              dp,
   output logic              dm,
   output logic              tx_oe,
   output logic              busy
);

   localparam int BCW = $clog2(CLKS_PER_BIT);
   localparam int DCW = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [DCW-1:0] DATA_ALL = DCW'(DATA_W);
   localparam logic [2:0]     ONES_MAX = 3'(MAX_ONES);
   localparam logic [2:0]     SE0_LAST = 3'(EOP_SE0_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [DCW-1:0]    data_cnt_q, data_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        ones_q, ones_d;
   logic              tx_ready_q, tx_ready_d;
   logic              tx_oe_q, tx_oe_d;

   logic tick, nxt_bit, se0_req, j_req, emit_data, bit_end;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      idx_d      = idx_q;
      data_cnt_d = data_cnt_q;
      shift_d    = shift_q;
      ones_d     = ones_q;
      tx_ready_d = tx_ready_q;
      tx_oe_d    = tx_oe_q;
      tick       = 1'b0;
      nxt_bit    = 1'b1;
      se0_req    = 1'b0;
      j_req      = 1'b0;
      emit_data  = 1'b0;
      bit_end    = (bit_cnt_q == BIT_LAST);

      if (state_q != IDLE) begin
         bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
      end

      // Each tick loads the bit that will be on the line from the next cycle on
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d    = SYNC;
               bit_cnt_d  = '0;
               idx_d      = 3'd0;
               data_cnt_d = '0;
               shift_d    = tx_data;
               ones_d     = 3'd0;
               tx_ready_d = 1'b0;
               tx_oe_d    = 1'b1;
               tick       = 1'b1;
               nxt_bit    = SYNC_PATTERN[0];
            end
         end
         SYNC: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  emit_data = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tick    = 1'b1;
                  nxt_bit = SYNC_PATTERN[idx_d];
               end
            end
         end
         DATA, STUFF: begin
            if (bit_end) begin
               if (state_q == DATA && ones_q == ONES_MAX) begin
                  state_d = STUFF;
                  tick    = 1'b1;
                  nxt_bit = 1'b0;
               end else if (data_cnt_q == DATA_ALL) begin
                  state_d = EOP_SE0;
                  idx_d   = 3'd0;
                  tick    = 1'b1;
                  se0_req = 1'b1;
               end else begin
                  emit_data = 1'b1;
               end
            end
         end
         EOP_SE0: begin
            if (bit_end) begin
               tick = 1'b1;
               if (idx_q == SE0_LAST) begin
                  state_d = EOP_J;
                  j_req   = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  se0_req = 1'b1;
               end
            end
         end
         EOP_J: begin
            if (bit_end) begin
               state_d    = IDLE;
               tx_ready_d = 1'b1;
               tx_oe_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (emit_data) begin
         state_d    = DATA;
         tick       = 1'b1;
         nxt_bit    = shift_q[0];
         shift_d    = shift_q >> 1;
         data_cnt_d = data_cnt_q + 1'b1;
      end

      if (tick && !se0_req && !j_req) begin
         ones_d = nxt_bit ? ones_q + 3'd1 : 3'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         idx_q      <= 3'd0;
         data_cnt_q <= '0;
         shift_q    <= '0;
         ones_q     <= 3'd0;
         tx_ready_q <= 1'b1;
         tx_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         idx_q      <= idx_d;
         data_cnt_q <= data_cnt_d;
         shift_q    <= shift_d;
         ones_q     <= ones_d;
         tx_ready_q <= tx_ready_d;
         tx_oe_q    <= tx_oe_d;
      end
   end

   usb_nrzi_enc u_nrzi (
      .clk      (clk),
      .reset    (reset),
      .bit_tick (tick),
      .bit_in   (nxt_bit),
      .se0_req  (se0_req),
      .j_req    (j_req),
      .dp       (dp),
      .dm       (dm)
   );

   assign tx_ready = tx_ready_q;
   assign tx_oe    = tx_oe_q;
   assign busy     = ~tx_ready_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Randomized bench for usb_tx_serializer: per-cycle line model plus NRZI/destuff decoder.
module tb_usb_tx_serializer;

   localparam int DW  = 32;
   localparam int CPB = 4;
   localparam logic [1:0] TJ   = 2'b10;
   localparam logic [1:0] TK   = 2'b01;
   localparam logic [1:0] TSE0 = 2'b00;

   logic          clk;
   logic          reset;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          dp;
   logic          dm;
   logic          tx_oe;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [1:0]    expq  [$];
   logic [DW-1:0] words [$];
   logic [1:0]    cap   [$];

   usb_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .dp       (dp),
      .dm       (dm),
      .tx_oe    (tx_oe),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Line states, one per bit, that a packet carrying w must put on the wire.
   function automatic int model_line(input logic [DW-1:0] w, output logic [1:0] ls [64]);
      bit   bq [$];
      int   run = 0;
      int   n   = 0;
      logic lvl = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bq.push_back(i == 7);
         run = (i == 7) ? run + 1 : 0;
      end
      for (int i = 0; i < DW; i++) begin
         bq.push_back(w[i]);
         run = w[i] ? run + 1 : 0;
         if (run == 6) begin
            bq.push_back(1'b0);
            run = 0;
         end
      end
      foreach (ls[i]) ls[i] = TJ;
      foreach (bq[i]) begin
         if (!bq[i]) lvl = ~lvl;
         ls[n] = lvl ? TJ : TK;
         n++;
      end
      ls[n]     = TSE0;
      ls[n + 1] = TSE0;
      ls[n + 2] = TJ;
      return n + 3;
   endfunction

   logic [1:0] m_ls [64];
   int         m_nb;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         expq.delete();
         words.delete();
      end else if (expq.size() > 0) begin
         void'(expq.pop_front());
      end else if (tx_valid) begin
         m_nb = model_line(tx_data, m_ls);
         for (int b = 0; b < m_nb; b++)
            for (int c = 0; c < CPB; c++) expq.push_back(m_ls[b]);
         words.push_back(tx_data);
      end
   end

   task automatic decode_check();
      int         nbit, run, nd, nst;
      logic [1:0] prev, ls;
      logic [7:0] sy;
      logic [DW-1:0] d;
      logic       b, serr;
      nbit = cap.size() / CPB;
      if (nbit < 11 || nbit > 60) begin
         chk("pkt_bits_range", nbit, 43);
         return;
      end
      prev = TJ; run = 0; nd = 0; nst = 0; sy = '0; d = '0; serr = 1'b0;
      for (int k = 0; k < nbit - 3; k++) begin
         ls   = cap[k * CPB + CPB / 2];
         b    = (ls == prev);
         prev = ls;
         if (k < 8) begin
            sy[k] = b;
            run   = b ? run + 1 : 0;
         end else if (run == 6) begin
            serr = serr | b;
            nst++;
            run = 0;
         end else begin
            if (nd < DW) d[nd] = b;
            nd++;
            run = b ? run + 1 : 0;
         end
      end
      chk("eop", {cap[(nbit-3)*CPB + CPB/2], cap[(nbit-2)*CPB + CPB/2], cap[(nbit-1)*CPB + CPB/2]},
          {TSE0, TSE0, TJ});
      chk("sync", sy, 8'h80);
      chk("stuff_bit_zero", serr, 0);
      chk("final_run_stuffed", run == 6, 0);
      chk("data_bits", nd, DW);
      chk("oe_len", cap.size(), (8 + nd + nst + 3) * CPB);
      chk("word_pending", words.size(), 1);
      if (words.size() > 0) chk("payload", d, words.pop_front());
   endtask

   logic [1:0] e_line;
   logic       e_oe;

   always @(negedge clk) begin
      if (reset || expq.size() == 0) begin
         e_line = TJ;
         e_oe   = 1'b0;
      end else begin
         e_line = expq[0];
         e_oe   = 1'b1;
      end
      chk("line", {dp, dm}, e_line);
      chk("tx_oe", tx_oe, e_oe);
      chk("tx_ready", tx_ready, !e_oe);
      chk("busy", busy, e_oe);
      chk("no_se1", dp & dm, 0);
      if (reset) cap.delete();
      else if (tx_oe) cap.push_back({dp, dm});
      else if (cap.size() > 0) begin
         decode_check();
         cap.delete();
      end
   end

   task automatic send(input logic [DW-1:0] w, input int exp_len);
      int k;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = w;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (tx_ready && k < 200);
      chk("accept_seen", tx_ready, 0);
      tx_valid = 1'b0;
      tx_data  = $urandom;
      k = 0;
      while (!tx_ready && k < 1000) begin
         k++;
         @(negedge clk);
      end
      chk("ready_timeout", k < 1000, 1);
      if (exp_len > 0) chk("pkt_cycles", k, exp_len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   logic [1:0]    p_ls [64];
   int            p_nb;
   int            k;
   logic [DW-1:0] w;

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_dp", dp, 1);
      chk("rst_dm", dm, 0);
      chk("rst_oe", tx_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);

      p_nb = model_line(32'h0000_0000, p_ls);
      chk("pin_len_zero", p_nb, 43);
      chk("pin_sync_line", {p_ls[0], p_ls[1], p_ls[2], p_ls[3], p_ls[4], p_ls[5], p_ls[6], p_ls[7]}, 16'h6665);
      chk("pin_first_data", p_ls[8], TJ);
      chk("pin_eop_start", p_ls[40], TSE0);
      p_nb = model_line(32'hFFFF_FFFF, p_ls);
      chk("pin_len_ones", p_nb, 48);
      p_nb = model_line(32'h0000_00FC, p_ls);
      chk("pin_len_fc", p_nb, 44);
      p_nb = model_line(32'hFC00_0000, p_ls);
      chk("pin_len_tail_stuff", p_nb, 44);
      chk("pin_tail_stuff_toggle", p_ls[40] ^ p_ls[39], 2'b11);
      chk("pin_tail_eop", p_ls[41], TSE0);

      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      send(32'h0000_0000, 172);
      send(32'hFFFF_FFFF, 192);
      send(32'h0000_00FC, 176);
      send(32'hFC00_0000, 176);

      // back-to-back with tx_valid held and tx_data disturbed mid-packet
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 32'hA5A5_0F0F;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (tx_ready && k < 50);
      chk("b2b_accept_a", tx_ready, 0);
      tx_data = 32'h1234_5678;
      k = 0;
      while (!tx_ready && k < 1000) begin
         k++;
         @(negedge clk);
      end
      chk("b2b_ready_a", tx_ready, 1);
      @(negedge clk);
      chk("b2b_gap_one_cycle", tx_ready, 0);
      for (int i = 0; i < 100; i++) begin
         tx_data = $urandom;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      k = 0;
      while (!tx_ready && k < 1000) begin
         k++;
         @(negedge clk);
      end
      chk("b2b_ready_b", tx_ready, 1);

      // reset in the middle of DATA
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 32'h5A5A_C3C3;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (56) @(negedge clk);
      chk("mid_busy_before_reset", tx_oe, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_dp", dp, 1);
      chk("mid_rst_dm", dm, 0);
      chk("mid_rst_oe", tx_oe, 0);
      chk("mid_rst_ready", tx_ready, 1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      send($urandom, 0);

      for (int r = 0; r < 40; r++) begin
         w = $urandom;
         if (r % 5 == 1) w = w | 32'hFC00_0000;
         if (r % 7 == 2) w = 32'hFFFF_FFFF ^ (32'h1 << $urandom_range(0, 31));
         send(w, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      chk("cap_drained", cap.size(), 0);
      chk("words_drained", words.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
